qc_ldpc_parity_encoder: RTL
===========================

Name: qc_ldpc_parity_encoder

Overview:
Parametrised quasi-cyclic LDPC parity encoder, the next generation of the single-rate 360-bit accumulator.
- Accepts the information bits serially with a valid/ready handshake.
- Fetches one generator row per circulant group from an external synchronous ROM with configurable latency, and XOR-accumulates the rotated row into a parity register.
- Streams parity out MSB-first with valid/ready, optionally passing systematic bits through first and optionally applying the final differential (running-XOR) accumulation.
- Sits between the bit-interleaver front end and the constellation mapper of the OFDM transmit chain.

Parameters:
Z, 360, circulant size (information bits per group).
NB_INFO, 12, number of information groups per codeword (K = Z*NB_INFO).
PAR_W, 360, parity register width (also ROM row width).
ROM_LAT, 1, ROM read latency in cycles (1..3).
ACC_MODE, 0, 0 = plain parity output; 1 = output bit k = p[k] XOR previous output bit (differential accumulator).
SYS_OUT, 0, 1 = forward each accepted info bit on dout before parity.

Ports:
clk  in  1  clock.
rst  in  1  asynchronous active-high reset.
start  in  1  one-cycle pulse; begins a codeword; ignored unless IDLE.
din  in  1  information bit.
din_valid  in  1  din qualifier.
din_ready  out  1  encoder accepts din this cycle.
rom_addr  out  clog2(NB_INFO)  generator row address (registered).
rom_data  in  PAR_W  row data, valid ROM_LAT cycles after rom_addr changes.
dout  out  1  output bit.
dout_valid  out  1  dout qualifier.
dout_ready  in  1  downstream accepts dout.
busy  out  1  high whenever not IDLE.
done  out  1  one-cycle pulse on the cycle the last parity bit is accepted.

Behaviour:
- Reset, and any cycle rst is high, forces the following. This applies mid-codeword too; the partial codeword is discarded and no done is issued.
  - State IDLE; accumulator, row register and all counters cleared.
  - Outputs: din_ready=0, dout=0, dout_valid=0, busy=0, done=0, rom_addr=0.
- States: IDLE, FETCH, ACCUM, DRAIN.
- IDLE + start:
  - clear accumulator, group counter g=0, rom_addr<=0;
  - go to FETCH.
- FETCH:
  - wait counter runs ROM_LAT cycles; din_ready=0;
  - on the final wait cycle, row register <= rom_data, bit counter j=0, then go to ACCUM.
  - Bubble per group is ROM_LAT+1 cycles.
- ACCUM:
  - din_ready=1, except when SYS_OUT=1: din_ready = dout_ready. The systematic bit appears as dout=din, dout_valid=din_valid, combinationally gated.
  - Transfer = din_valid & din_ready. Per transfer:
    - if din=1, accumulator <= accumulator XOR row;
    - row <= {row[0], row[PAR_W-1:1]} (rotate right by 1);
    - j++.
  - Transfer with j=Z-1 ends the group:
    - if g=NB_INFO-1, go to DRAIN with output index k=PAR_W-1 and running bit r=0;
    - otherwise g++, rom_addr<=g+1, go to FETCH.
- DRAIN:
  - dout_valid=1; dout = p[k] (ACC_MODE=0) or p[k] XOR r (ACC_MODE=1).
  - On dout_ready: r<=dout, k--.
  - Transfer at k=0: done=1, go to IDLE.
  - dout is held stable while dout_valid & !dout_ready.
- start outside IDLE has no effect.
- din_valid while din_ready=0 is not consumed.
- Counter widths:
  - j is clog2(Z); g is clog2(NB_INFO); k is clog2(PAR_W).
  - No wrap beyond the terminal values.
- Throughput: 1 bit/cycle in ACCUM and DRAIN when not back-pressured.

Decomposition:
- Shared package (ldpc_pkg):
  - state encoding typedef;
  - the clog2 helper;
  - default Z/NB_INFO/PAR_W constants per code rate.
- Natural sub-module: qc_row_rotator. It holds the row register, loads from rom_data and rotates on a shift enable, and outputs the current row. It is reusable by the decoder check-node path.

Test Plan:
Unless stated, parameters are Z=4, NB_INFO=2, PAR_W=4, ROM_LAT=1, SYS_OUT=0, and ROM holds row0=4'b0001, row1=4'b0011.
1. Info bits 1111 then 0000, ACC_MODE=0 -> accumulator 4'b1111; dout 1,1,1,1; done on the 4th parity transfer.
2. Same stimulus with ACC_MODE=1 -> dout 1,0,1,0.
3. Info bits 0000 then 1000 (first bit of group1 set) -> parity 4'b0011; dout 0,0,1,1.
4. Check handshake timing:
   - din_ready is 0 for exactly 2 cycles between groups, and rom_addr=1 during that gap.
   - Drive dout_ready low for 3 cycles mid-DRAIN -> dout/dout_valid held, no bit lost or duplicated.
5. Assert rst for 1 cycle after 3 info bits of group1 -> all outputs 0, busy=0, no done. A following start with scenario 1 stimulus reproduces 1,1,1,1.
6. SYS_OUT=1 with scenario 1 stimulus -> dout 1,1,1,1,0,0,0,0,1,1,1,1. Also run defaults (Z=360, NB_INFO=12) with random bits against a reference model; parity must match.

Source files
------------

// File: rtl/qc_ldpc_parity_encoder_pkg.sv
// rtl/qc_ldpc_parity_encoder_pkg.sv - shared types, constants and helpers for the QC-LDPC parity encoder
package qc_ldpc_parity_encoder_pkg;

   // Encoder control states
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_ACCUM = 2'd2,
      ST_DRAIN = 2'd3
   } enc_state_e;

   // Default code geometry (360-bit circulants, 12 information groups)
   localparam int DEF_Z       = 360;
   localparam int DEF_NB_INFO = 12;
   localparam int DEF_PAR_W   = 360;

   // Alternative geometries sharing the same circulant size
   localparam int R12_NB_INFO = 90;
   localparam int R12_PAR_W   = 32400;
   localparam int R34_NB_INFO = 135;
   localparam int R34_PAR_W   = 16200;

   // Ceiling log2, never below 1 so degenerate counters still get a bit
   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/qc_ldpc_parity_encoder_row_rotator.sv
// rtl/qc_ldpc_parity_encoder_row_rotator.sv - generator row register with load and rotate-right-by-one
module qc_ldpc_parity_encoder_row_rotator #(
   parameter int W = 360
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic         shift_i,
   input  logic [W-1:0] row_i,
   output logic [W-1:0] row_o
);

   logic [W-1:0] row_q;

   // Load has priority over rotation; rotation models the circulant column step
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
      end else if (load_i) begin
         row_q <= row_i;
      end else if (shift_i) begin
         row_q <= {row_q[0], row_q[W-1:1]};
      end
   end

   assign row_o = row_q;

endmodule

// File: rtl/qc_ldpc_parity_encoder.sv
// rtl/qc_ldpc_parity_encoder.sv - serial quasi-cyclic LDPC parity encoder with ROM-fed generator rows
module qc_ldpc_parity_encoder
   import qc_ldpc_parity_encoder_pkg::*;
#(
   parameter int Z        = DEF_Z,
   parameter int NB_INFO  = DEF_NB_INFO,
   parameter int PAR_W    = DEF_PAR_W,
   parameter int ROM_LAT  = 1,
   parameter int ACC_MODE = 0,
   parameter int SYS_OUT  = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       din,
   input  logic                       din_valid,
   output logic                       din_ready,
   output logic [clog2(NB_INFO)-1:0]  rom_addr,
   input  logic [PAR_W-1:0]           rom_data,
   output logic                       dout,
   output logic                       dout_valid,
   input  logic                       dout_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int JW = clog2(Z);
   localparam int GW = clog2(NB_INFO);
   localparam int KW = clog2(PAR_W);

   enc_state_e        state_q, state_d;
   logic [PAR_W-1:0]  acc_q, acc_d;
   logic [PAR_W-1:0]  row;
   logic [JW-1:0]     j_q, j_d;
   logic [GW-1:0]     g_q, g_d;
   logic [KW-1:0]     k_q, k_d;
   logic              r_q, r_d;
   logic [1:0]        wait_q, wait_d;
   logic              row_load, row_shift;
   logic              din_xfer, dout_xfer;
   logic              j_last, g_last, k_zero, wait_last;
   logic              drain_bit;

   assign din_xfer  = (state_q == ST_ACCUM) && din_valid && din_ready;
   assign dout_xfer = (state_q == ST_DRAIN) && dout_ready;
   assign j_last    = (j_q == JW'(Z - 1));
   assign g_last    = (g_q == GW'(NB_INFO - 1));
   assign k_zero    = (k_q == '0);
   // The fetch window is ROM_LAT+1 cycles so the ROM sees the new address for a full cycle first
   assign wait_last = (wait_q == 2'(ROM_LAT));
   assign drain_bit = acc_q[k_q] ^ (r_q & (ACC_MODE != 0));
   // The group counter is itself the registered ROM address
   assign rom_addr  = g_q;

   qc_ldpc_parity_encoder_row_rotator #(
      .W (PAR_W)
   ) u_row (
      .clk     (clk),
      .rst     (rst),
      .load_i  (row_load),
      .shift_i (row_shift),
      .row_i   (rom_data),
      .row_o   (row)
   );

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start)     state_d = ST_FETCH;
         ST_FETCH: if (wait_last) state_d = ST_ACCUM;
         ST_ACCUM: if (din_xfer && j_last) state_d = g_last ? ST_DRAIN : ST_FETCH;
         ST_DRAIN: if (dout_xfer && k_zero) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Handshake and output-bit selection
   always_comb begin
      din_ready  = 1'b0;
      dout       = 1'b0;
      dout_valid = 1'b0;
      done       = 1'b0;
      busy       = (state_q != ST_IDLE);
      case (state_q)
         ST_ACCUM: begin
            if (SYS_OUT != 0) begin
               din_ready  = dout_ready;
               dout       = din;
               dout_valid = din_valid;
            end else begin
               din_ready  = 1'b1;
            end
         end
         ST_DRAIN: begin
            dout_valid = 1'b1;
            dout       = drain_bit;
            done       = dout_ready && k_zero;
         end
         default: ;
      endcase
   end

   // Datapath next-state: accumulation, counters and row register control
   always_comb begin
      acc_d     = acc_q;
      j_d       = j_q;
      g_d       = g_q;
      k_d       = k_q;
      r_d       = r_q;
      wait_d    = wait_q;
      row_load  = 1'b0;
      row_shift = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               acc_d  = '0;
               g_d    = '0;
               wait_d = '0;
            end
         end
         ST_FETCH: begin
            if (wait_last) begin
               row_load = 1'b1;
               j_d      = '0;
               wait_d   = '0;
            end else begin
               wait_d   = wait_q + 2'd1;
            end
         end
         ST_ACCUM: begin
            if (din_xfer) begin
               row_shift = 1'b1;
               if (din) acc_d = acc_q ^ row;
               if (j_last) begin
                  if (g_last) begin
                     k_d = KW'(PAR_W - 1);
                     r_d = 1'b0;
                  end else begin
                     g_d    = g_q + 1'b1;
                     wait_d = '0;
                  end
               end else begin
                  j_d = j_q + 1'b1;
               end
            end
         end
         ST_DRAIN: begin
            if (dout_ready) begin
               r_d = drain_bit;
               if (!k_zero) k_d = k_q - 1'b1;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q  <= '0;
         j_q    <= '0;
         g_q    <= '0;
         k_q    <= '0;
         r_q    <= 1'b0;
         wait_q <= '0;
      end else begin
         acc_q  <= acc_d;
         j_q    <= j_d;
         g_q    <= g_d;
         k_q    <= k_d;
         r_q    <= r_d;
         wait_q <= wait_d;
      end
   end

endmodule
